ama_riscv_fetch: RTL and testbench
==================================

// Module: ama_riscv_fetch
// PURPOSE
//  Instruction-fetch (IF) stage: owns the PC register, drives the synchronous IMEM, and delivers inst_id/pc_id to the decoder.
//  Executes the decoder's control: pc_sel, pc_we, stall_if and clear_if.
//  Inserts NOP bubbles for reset, stall and flush, and keeps fetch/bubble performance counters.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset and on PC_SEL_START_ADDR
//  IMEM_AW       14             IMEM word-address width
//  RST_BUBBLES   1              NOP cycles issued after rst deasserts (0..3)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        reset, synchronous, active-high
//  pc_sel        in   2        next-PC select from decoder
//  pc_we         in   1        PC write enable from decoder
//  stall_if      in   1        decoder stall request
//  clear_if      in   1        flush request (taken branch or jump resolved in EX)
//  alu_out       in   32       redirect target computed in EX
//  imem_rdata    in   32       IMEM read data; valid 1 cycle after imem_addr
//  imem_addr     out  IMEM_AW  IMEM word address
//  imem_en       out  1        IMEM read enable
//  inst_id       out  32       instruction presented to ID
//  pc_id         out  32       PC of inst_id
//  pc_id_inc4    out  32       pc_id + 4
//  misalign_err  out  1        sticky flag: redirect target had bit[1] set
//  fetch_cnt     out  32       count of non-bubble instructions delivered to ID
//  bubble_cnt    out  32       count of bubbles delivered to ID (excluding the reset sequence)
// BEHAVIOUR
//  Reset values: pc=RESET_VECTOR; rst_cnt=RST_BUBBLES; stall_q=0; clear_q=0; misalign_err=0; both counters=0.
//  During rst: imem_en=1, imem_addr=RESET_VECTOR[IMEM_AW+1:2], inst_id=NOP (32'h0000_0013).
//  pc_next mux:
//   - PC_SEL_INC4 -> pc+4
//   - PC_SEL_ALU -> {alu_out[31:2],2'b00}
//   - PC_SEL_START_ADDR -> RESET_VECTOR
//   - PC_SEL_RSVD -> pc+4
//  Arithmetic is 32-bit modulo: pc=32'hFFFF_FFFC + 4 wraps to 0.
//  pc_upd = clear_if | (pc_we & ~stall_if & (rst_cnt==0)).
//  clear_if has priority: when clear_if=1, the PC is written even if stall_if=1 or pc_we=0.
//  PC update: pc <= pc_next when pc_upd; otherwise pc holds.
//  imem_addr = pc_upd ? pc_next[IMEM_AW+1:2] : pc[IMEM_AW+1:2] (combinational).
//  Consequence: imem_rdata in cycle t always belongs to pc(t). pc_id=pc and pc_id_inc4=pc+4.
//  A held PC re-reads the same word, so no instruction hold register is required.
//  Registered flags: stall_q<=stall_if and clear_q<=clear_if.
//  Bubble condition: bubble = (rst_cnt!=0) | stall_q | clear_q. inst_id = bubble ? NOP : imem_rdata.
//  Latency: a redirect asserted in cycle t (clear_if=1) gives inst_id=NOP in t+1 and the target instruction in t+1 only if
//   clear_q is low; because clear_q=1 in t+1, the target instruction appears in t+2.
//  rst_cnt decrements once per cycle after rst deasserts, saturating at 0.
//   While rst_cnt!=0 the PC holds at RESET_VECTOR, so the first real instruction is the word at RESET_VECTOR.
//  misalign_err is set when pc_sel==PC_SEL_ALU, pc_upd=1 and alu_out[1]=1. It is cleared only by rst. alu_out[0] is ignored.
//  Counters (mod 2^32, wrap with no flag):
//   - fetch_cnt increments when ~bubble.
//   - bubble_cnt increments when bubble & (rst_cnt==0).
//  Reset mid-operation: all state returns to reset values on the next edge, and in-flight stall/clear state is discarded.
//  imem_en=1 in every cycle. No IMEM write path.
// STRUCTURE
//  Shared defines file: PC_SEL_INC4=2'd0, PC_SEL_ALU=2'd1, PC_SEL_START_ADDR=2'd2, PC_SEL_RSVD=2'd3, and NOP_INST=32'h0000_0013.
//  Sub-module ama_riscv_perf_cnt (32-bit enabled wrap counter with synchronous reset), instantiated twice.
//  Everything else (PC register, next-PC mux, bubble logic) is flat in this module.
// TESTING
//  1. Reset release, RESET_VECTOR=0x0, RST_BUBBLES=1:
//     inst_id=NOP for 1 cycle, then mem[0] with pc_id=0x0, then mem[1] with pc_id=0x4.
//  2. stall_if=1 for 2 cycles at pc=0x10: pc holds at 0x10, imem_addr=4; inst_id=NOP for 2 cycles;
//     then inst@0x10 is delivered; bubble_cnt=2.
//  3. clear_if=1, pc_sel=ALU, alu_out=0x100 at pc=0x20: imem_addr=0x40 the same cycle, inst_id=NOP next cycle,
//     then inst@0x100 with pc_id=0x100.
//  4. clear_if=1 together with stall_if=1 and pc_we=0: PC still redirects to alu_out; a single bubble is counted.
//  5. Redirect to alu_out=0x206: pc becomes 0x204 and misalign_err=1 and stays set until rst.
//     Separately, pc=0xFFFF_FFFC with INC4: pc wraps to 0x0.
//  6. rst asserted during a stall: next cycle pc=RESET_VECTOR, counters=0, inst_id=NOP.

Source files
------------

// File: rtl/ama_riscv_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: next-PC select encodings and the NOP bubble.
package ama_riscv_fetch_pkg;

   localparam logic [1:0]  PC_SEL_INC4       = 2'd0;
   localparam logic [1:0]  PC_SEL_ALU        = 2'd1;
   localparam logic [1:0]  PC_SEL_START_ADDR = 2'd2;
   localparam logic [1:0]  PC_SEL_RSVD       = 2'd3;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST          = 32'h0000_0013;

   function automatic logic [31:0] pc_inc4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ama_riscv_perf_cnt.sv
// 32-bit enabled performance counter; wraps silently, cleared by synchronous reset.
module ama_riscv_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_i,
   output logic [31:0] cnt_o
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   assign cnt_d = en_i ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 32'd0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/ama_riscv_fetch.sv
// IF stage: PC register, next-PC mux, IMEM addressing and NOP bubble insertion.
// The IMEM address is steered by the same-cycle PC update so read data always belongs to the current PC.
module ama_riscv_fetch
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          IMEM_AW      = 14,
   parameter int          RST_BUBBLES  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         pc_sel,
   input  logic               pc_we,
   input  logic               stall_if,
   input  logic               clear_if,
   input  logic [31:0]        alu_out,
   input  logic [31:0]        imem_rdata,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               imem_en,
   output logic [31:0]        inst_id,
   output logic [31:0]        pc_id,
   output logic [31:0]        pc_id_inc4,
   output logic               misalign_err,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        bubble_cnt
);

   localparam logic [1:0] RST_CNT_INIT = 2'(RST_BUBBLES);

   logic [31:0] pc_q, pc_d, pc_next;
   logic [1:0]  rst_cnt_q, rst_cnt_d;
   logic        stall_q, clear_q;
   logic        misalign_q, misalign_d;
   logic        rst_done;
   logic        pc_upd;
   logic        bubble;
   logic        unused_alu_lsb;

   assign unused_alu_lsb = alu_out[0];

   always_comb begin
      pc_next = pc_inc4(pc_q);
      case (pc_sel)
         PC_SEL_INC4:       pc_next = pc_inc4(pc_q);
         PC_SEL_ALU:        pc_next = {alu_out[31:2], 2'b00};
         PC_SEL_START_ADDR: pc_next = RESET_VECTOR;
         PC_SEL_RSVD:       pc_next = pc_inc4(pc_q);
         default:           pc_next = pc_inc4(pc_q);
      endcase
   end

   assign rst_done = (rst_cnt_q == 2'd0);

   // A flush always redirects, even over a stall or a deasserted write enable.
   assign pc_upd     = clear_if | (pc_we & ~stall_if & rst_done);
   assign pc_d       = pc_upd ? pc_next : pc_q;
   assign rst_cnt_d  = rst_done ? 2'd0 : rst_cnt_q - 2'd1;
   assign misalign_d = misalign_q | ((pc_sel == PC_SEL_ALU) & pc_upd & alu_out[1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VECTOR;
         rst_cnt_q  <= RST_CNT_INIT;
         stall_q    <= 1'b0;
         clear_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         rst_cnt_q  <= rst_cnt_d;
         stall_q    <= stall_if;
         clear_q    <= clear_if;
         misalign_q <= misalign_d;
      end
   end

   assign bubble = ~rst_done | stall_q | clear_q;

   assign imem_en   = 1'b1;
   assign imem_addr = rst    ? RESET_VECTOR[IMEM_AW+1:2] :
                      pc_upd ? pc_next[IMEM_AW+1:2]      : pc_q[IMEM_AW+1:2];

   assign inst_id      = (rst | bubble) ? NOP_INST : imem_rdata;
   assign pc_id        = pc_q;
   assign pc_id_inc4   = pc_inc4(pc_q);
   assign misalign_err = misalign_q;

   ama_riscv_perf_cnt u_fetch_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (~bubble),
      .cnt_o (fetch_cnt)
   );

   // Reset-sequence bubbles are not counted as pipeline bubbles.
   ama_riscv_perf_cnt u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .en_i  (bubble & rst_done),
      .cnt_o (bubble_cnt)
   );

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Directed bench for ama_riscv_fetch with a synchronous IMEM model holding 0xC0DE0000 + word index.
module tb_ama_riscv_fetch;
   import ama_riscv_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  pc_sel;
   logic        pc_we;
   logic        stall_if;
   logic        clear_if;
   logic [31:0] alu_out;
   logic [31:0] imem_rdata;
   logic [13:0] imem_addr;
   logic        imem_en;
   logic [31:0] inst_id;
   logic [31:0] pc_id;
   logic [31:0] pc_id_inc4;
   logic        misalign_err;
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;

   logic [31:0] mem [0:16383];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   ama_riscv_fetch #(
      .RESET_VECTOR (32'h0000_0000),
      .IMEM_AW      (14),
      .RST_BUBBLES  (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_sel       (pc_sel),
      .pc_we        (pc_we),
      .stall_if     (stall_if),
      .clear_if     (clear_if),
      .alu_out      (alu_out),
      .imem_rdata   (imem_rdata),
      .imem_addr    (imem_addr),
      .imem_en      (imem_en),
      .inst_id      (inst_id),
      .pc_id        (pc_id),
      .pc_id_inc4   (pc_id_inc4),
      .misalign_err (misalign_err),
      .fetch_cnt    (fetch_cnt),
      .bubble_cnt   (bubble_cnt)
   );

   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply inputs just after a rising edge, then settle to the falling edge for checking.
   task automatic drive(input logic r, input logic [1:0] sel, input logic we,
                        input logic st, input logic cl, input logic [31:0] alu);
      @(posedge clk);
      #1;
      rst      = r;
      pc_sel   = sel;
      pc_we    = we;
      stall_if = st;
      clear_if = cl;
      alu_out  = alu;
      @(negedge clk);
      $display("[TB] rst=%0b sel=%0d we=%0b st=%0b cl=%0b alu=%h | pc_id=%h addr=%h inst=%h fc=%0d bc=%0d mis=%0b",
               r, sel, we, st, cl, alu, pc_id, imem_addr, inst_id, fetch_cnt, bubble_cnt, misalign_err);
   endtask

   task automatic run(); // normal sequential fetch
      drive(1'b0, PC_SEL_INC4, 1'b1, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      imem_rdata = 32'h0;
      rst = 1'b1; pc_sel = PC_SEL_INC4; pc_we = 1'b1;
      stall_if = 1'b0; clear_if = 1'b0; alu_out = 32'h0;

      // Reset state
      drive(1'b1, PC_SEL_INC4, 1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b1, PC_SEL_INC4, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("rst_inst",     inst_id, NOP_INST);
      chk("rst_addr",     32'(imem_addr), 32'h0);
      chk("rst_en",       32'(imem_en), 32'h1);
      chk("rst_pc",       pc_id, 32'h0);
      chk("rst_fcnt",     fetch_cnt, 32'h0);
      chk("rst_bcnt",     bubble_cnt, 32'h0);
      chk("rst_mis",      32'(misalign_err), 32'h0);

      // 1. Reset release: one NOP, then mem[0], mem[1]
      run();
      chk("t1_bubble",    inst_id, NOP_INST);
      chk("t1_hold_addr", 32'(imem_addr), 32'h0);
      run();
      chk("t1_inst0",     inst_id, 32'hC0DE_0000);
      chk("t1_pc0",       pc_id, 32'h0);
      chk("t1_inc4",      pc_id_inc4, 32'h4);
      chk("t1_addr1",     32'(imem_addr), 32'h1);
      chk("t1_bcnt",      bubble_cnt, 32'h0);
      run();
      chk("t1_inst1",     inst_id, 32'hC0DE_0001);
      chk("t1_pc1",       pc_id, 32'h4);
      chk("t1_fcnt",      fetch_cnt, 32'h1);

      // 2. Two-cycle stall at pc=0x10
      run(); run();
      chk("t2_pre_pc",    pc_id, 32'hC);
      drive(1'b0, PC_SEL_INC4, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("t2_pc",        pc_id, 32'h10);
      chk("t2_addr",      32'(imem_addr), 32'h4);
      chk("t2_inst_pre",  inst_id, 32'hC0DE_0004);
      drive(1'b0, PC_SEL_INC4, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("t2_nop1",      inst_id, NOP_INST);
      chk("t2_hold_pc",   pc_id, 32'h10);
      chk("t2_hold_addr", 32'(imem_addr), 32'h4);
      drive(1'b0, PC_SEL_INC4, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("t2_nop2",      inst_id, NOP_INST);
      run();
      chk("t2_inst",      inst_id, 32'hC0DE_0004);
      chk("t2_pc_after",  pc_id, 32'h10);
      chk("t2_bcnt",      bubble_cnt, 32'h2);
      chk("t2_fcnt",      fetch_cnt, 32'h5);

      // 3. Redirect to 0x100 from pc=0x20
      run(); run(); run();
      drive(1'b0, PC_SEL_ALU, 1'b1, 1'b0, 1'b1, 32'h100);
      chk("t3_pc",        pc_id, 32'h20);
      chk("t3_addr",      32'(imem_addr), 32'h40);
      drive(1'b0, PC_SEL_INC4, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("t3_nop",       inst_id, NOP_INST);
      chk("t3_pc_tgt",    pc_id, 32'h100);
      run();
      chk("t3_inst",      inst_id, 32'hC0DE_0040);
      chk("t3_pc_id",     pc_id, 32'h100);
      chk("t3_bcnt",      bubble_cnt, 32'h3);
      chk("t3_fcnt",      fetch_cnt, 32'hA);

      // 4. clear_if wins over stall_if and pc_we=0
      drive(1'b0, PC_SEL_ALU, 1'b0, 1'b1, 1'b1, 32'h300);
      chk("t4_addr",      32'(imem_addr), 32'hC0);
      chk("t4_inst",      inst_id, 32'hC0DE_0041);
      drive(1'b0, PC_SEL_INC4, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("t4_pc",        pc_id, 32'h300);
      chk("t4_nop",       inst_id, NOP_INST);
      run();
      chk("t4_tgt",       inst_id, 32'hC0DE_00C0);
      chk("t4_bcnt",      bubble_cnt, 32'h4);
      chk("t4_fcnt",      fetch_cnt, 32'hC);

      // 5. Misaligned redirect, then 32-bit PC wrap
      drive(1'b0, PC_SEL_ALU, 1'b1, 1'b0, 1'b1, 32'h206);
      chk("t5_mis_pre",   32'(misalign_err), 32'h0);
      chk("t5_addr",      32'(imem_addr), 32'h81);
      drive(1'b0, PC_SEL_INC4, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("t5_pc",        pc_id, 32'h204);
      chk("t5_mis",       32'(misalign_err), 32'h1);
      run();
      chk("t5_inst",      inst_id, 32'hC0DE_0081);
      drive(1'b0, PC_SEL_ALU, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      chk("t5_wr_addr",   32'(imem_addr), 32'h3FFF);
      run();
      chk("t5_pc_max",    pc_id, 32'hFFFF_FFFC);
      chk("t5_inc4_wrap", pc_id_inc4, 32'h0);
      chk("t5_addr_wrap", 32'(imem_addr), 32'h0);
      run();
      chk("t5_pc_wrap",   pc_id, 32'h0);
      chk("t5_inst_wrap", inst_id, 32'hC0DE_0000);
      chk("t5_mis_stky",  32'(misalign_err), 32'h1);

      // 6. Reset asserted during a stall
      drive(1'b0, PC_SEL_INC4, 1'b1, 1'b1, 1'b0, 32'h0);
      drive(1'b1, PC_SEL_INC4, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("t6_rst_inst",  inst_id, NOP_INST);
      chk("t6_rst_addr",  32'(imem_addr), 32'h0);
      run();
      chk("t6_pc",        pc_id, 32'h0);
      chk("t6_fcnt",      fetch_cnt, 32'h0);
      chk("t6_bcnt",      bubble_cnt, 32'h0);
      chk("t6_mis",       32'(misalign_err), 32'h0);
      chk("t6_nop",       inst_id, NOP_INST);
      run();
      chk("t6_inst0",     inst_id, 32'hC0DE_0000);
      chk("t6_bcnt2",     bubble_cnt, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
